// File: rtl/pipe_pkg.sv
// Shared parameters for the arithmetic pipeline F = ((A+B)+(C-D))*D and the
// blocks that consume its results.
//   PIPE_N      data width of F
//   PIPE_LAT    clock edges from issue sample to F valid at the pipeline output
//   PIPE_DEPTH  result FIFO entries (power of 2, >= 2)
//   PIPE_OCC_W  width of an occupancy count able to hold 0..PIPE_DEPTH
package pipe_pkg;

    localparam int PIPE_N     = 10;
    localparam int PIPE_LAT   = 3;
    localparam int PIPE_DEPTH = 4;
    localparam int PIPE_OCC_W = $clog2(PIPE_DEPTH) + 1;

endpackage

// File: rtl/pipe_sync_fifo.sv
// Synchronous result FIFO.
// Ports:
//   clk        clock, all state on posedge
//   rst        synchronous active-high reset (pointers and count only)
//   push       write wdata into the tail this edge
//   wdata      data to write
//   pop        retire the head this edge
//   rdata      current head entry (meaningful only when occupancy != 0)
//   occupancy  number of stored entries, 0..DEPTH
// Pointers are clog2(DEPTH) bits and wrap naturally; the occupancy count is
// what separates full from empty.
module pipe_sync_fifo
    import pipe_pkg::*;
#(
    parameter int N     = PIPE_N,
    parameter int DEPTH = PIPE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [N-1:0]             wdata,
    input  logic                     pop,
    output logic [N-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);

    logic [N-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the count and pointers decide
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

`ifndef SYNTHESIS
    // The issue-credit rule upstream must make this unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && occupancy == FULL_COUNT))
        else $error("pipe_sync_fifo: push into full FIFO without pop");
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && occupancy == '0))
        else $error("pipe_sync_fifo: pop from empty FIFO");
`endif

endmodule

// File: rtl/pipe_result_capture.sv
// Captures results of the fixed-latency, non-stalling arithmetic pipeline.
// Each accepted issue is tracked through a LAT-deep valid shift register;
// when the token reaches the end, f_in is written into the result FIFO.
// Issue credit keeps results in flight plus results stored within DEPTH.
// Ports:
//   clk        clock, all state on posedge
//   rst        synchronous active-high reset
//   issue      an operand set is driven onto the pipeline this cycle
//   issue_ok   credit available; an issue is tracked only when this is high
//   f_in       pipeline output F
//   res_valid  FIFO head holds a result
//   res_ready  consumer accepts the head this cycle
//   res_data   FIFO head, forced to 0 when res_valid is low
//   occupancy  number of stored results
//   err_drop   sticky flag: an issue arrived without credit (result lost)
module pipe_result_capture
    import pipe_pkg::*;
#(
    parameter int N     = PIPE_N,
    parameter int LAT   = PIPE_LAT,
    parameter int DEPTH = PIPE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue,
    output logic                     issue_ok,
    input  logic [N-1:0]             f_in,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [N-1:0]             res_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     err_drop
);

    // Wide enough for occupancy + inflight without overflow.
    localparam int CNT_W = $clog2(DEPTH + LAT + 1);

    logic [LAT-1:0]   vsr;
    logic [CNT_W-1:0] inflight;
    logic             tok;
    logic             push;
    logic             pop;
    logic [N-1:0]     head;

    // Credit depends on registers only, so issue and res_ready never
    // combinationally reach issue_ok.
    // NOTE: every variable written in always_comb gets a default first so no
    // latch is inferred.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CNT_W'(vsr[i]);
        end
    end

    assign issue_ok = (CNT_W'(occupancy) + inflight) < CNT_W'(DEPTH);
    assign tok      = issue & issue_ok;
    assign push     = vsr[LAT-1];
    assign res_valid = (occupancy != '0);
    assign pop      = res_valid & res_ready;
    assign res_data = res_valid ? head : '0;

    // Token position i means the operands were sampled i+1 edges ago.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsr <= '0;
        end else begin
            vsr[0] <= tok;
            for (int i = 1; i < LAT; i++) begin
                vsr[i] <= vsr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_drop <= 1'b0;
        end else if (issue && !issue_ok) begin
            err_drop <= 1'b1;
        end
    end

    pipe_sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .wdata     (f_in),
        .pop       (pop),
        .rdata     (head),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_pipe_result_capture.sv
module tb_pipe_result_capture;
    import pipe_pkg::*;

    localparam int N = PIPE_N;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  issue;
    logic                  issue_ok;
    logic [N-1:0]          f_in;
    logic                  res_valid;
    logic                  res_ready;
    logic [N-1:0]          res_data;
    logic [PIPE_OCC_W-1:0] occupancy;
    logic                  err_drop;

    // Operands and a behavioural 3-stage model of the arithmetic pipeline.
    logic [N-1:0] op_a, op_b, op_c, op_d;
    logic [N-1:0] p1_ab, p1_cd, p1_d, p2_s, p2_d, p3_f;

    always @(posedge clk) begin
        p1_ab <= op_a + op_b;
        p1_cd <= op_c - op_d;
        p1_d  <= op_d;
        p2_s  <= p1_ab + p1_cd;
        p2_d  <= p1_d;
        p3_f  <= p2_s * p2_d;
    end
    assign f_in = p3_f;

    always #5 clk = ~clk;

    pipe_result_capture dut (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .issue_ok  (issue_ok),
        .f_in      (f_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .occupancy (occupancy),
        .err_drop  (err_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are observed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int a, input int b, input int c, input int d);
        op_a = N'(a);
        op_b = N'(b);
        op_c = N'(c);
        op_d = N'(d);
    endtask

    // Test 3 operand sets and their hand-computed results.
    int t3_ops [6][4] = '{'{3,4,7,2}, '{1,1,1,1}, '{0,0,9,4},
                          '{6,2,3,5}, '{1,0,0,1}, '{2,0,0,1}};
    int t3_exp [4]    = '{24, 2, 20, 30};

    int issued;
    int received;

    initial begin
        rst = 1'b1;
        issue = 1'b0;
        res_ready = 1'b0;
        set_ops(0, 0, 0, 0);

        // 1. Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", int'(res_valid), 0);
        check("rst_data", int'(res_data), 0);
        check("rst_occ", int'(occupancy), 0);
        check("rst_issue_ok", int'(issue_ok), 1);
        check("rst_err", int'(err_drop), 0);

        // 2. Single issue: (1+2)+(5-3)=5, *3 = 15, visible after edge k+3 only
        set_ops(1, 2, 5, 3);
        issue = 1'b1;
        res_ready = 1'b1;
        tick();                               // edge k
        issue = 1'b0;
        check("t2_k0_valid", int'(res_valid), 0);
        tick();
        check("t2_k1_valid", int'(res_valid), 0);
        tick();
        check("t2_k2_valid", int'(res_valid), 0);
        tick();
        check("t2_k3_valid", int'(res_valid), 1);
        check("t2_k3_data", int'(res_data), 15);
        tick();
        check("t2_k4_valid", int'(res_valid), 0);
        check("t2_k4_data", int'(res_data), 0);
        check("t2_err", int'(err_drop), 0);

        // 3. Six consecutive issues with no consumer
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_ops(t3_ops[i][0], t3_ops[i][1], t3_ops[i][2], t3_ops[i][3]);
            issue = 1'b1;
            tick();
            if (i == 2) check("t3_ok_after3", int'(issue_ok), 1);
            if (i == 3) begin
                check("t3_ok_after4", int'(issue_ok), 0);
                check("t3_err_after4", int'(err_drop), 0);
            end
            if (i == 4) check("t3_err_after5", int'(err_drop), 1);
        end
        issue = 1'b0;
        tick();
        tick();
        check("t3_occ", int'(occupancy), 4);
        check("t3_ok_full", int'(issue_ok), 0);
        check("t3_head", int'(res_data), t3_exp[0]);
        check("t3_err_sticky", int'(err_drop), 1);

        // 4. Pop from full, refill with a token that lands on a popping edge
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("t4_pop_occ", int'(occupancy), 3);
        check("t4_pop_head", int'(res_data), t3_exp[1]);
        check("t4_pop_ok", int'(issue_ok), 1);
        set_ops(2, 3, 4, 1);                  // (5+3)*1 = 8
        issue = 1'b1;
        tick();
        issue = 1'b0;
        check("t4_ok_credit", int'(issue_ok), 0);
        tick();
        tick();
        res_ready = 1'b1;
        tick();                               // push and pop on the same edge
        check("t4_same_occ", int'(occupancy), 3);
        check("t4_same_head", int'(res_data), t3_exp[2]);
        tick();
        check("t4_drain0", int'(res_data), t3_exp[3]);
        tick();
        check("t4_drain1", int'(res_data), 8);
        check("t4_drain1_occ", int'(occupancy), 1);
        tick();
        check("t4_empty_valid", int'(res_valid), 0);
        check("t4_empty_occ", int'(occupancy), 0);
        res_ready = 1'b0;

        // 5. Reset on the edge of the 2nd capture
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_err_cleared", int'(err_drop), 0);
        set_ops(1, 2, 5, 3);                  // 15
        issue = 1'b1;
        tick();                               // t1
        set_ops(2, 2, 2, 2);                  // (4+0)*2 = 8
        tick();                               // t2
        set_ops(4, 0, 0, 1);                  // (4-1)*1 = 3
        tick();                               // t3
        issue = 1'b0;
        tick();                               // t4: first capture
        check("t5_first", int'(res_data), 15);
        rst = 1'b1;
        tick();                               // t5: second capture edge
        rst = 1'b0;
        check("t5_rst_occ", int'(occupancy), 0);
        check("t5_rst_valid", int'(res_valid), 0);
        tick();                               // t6: third result at f_in, ignored
        check("t5_third_occ", int'(occupancy), 0);
        tick();
        check("t5_late_valid", int'(res_valid), 0);
        check("t5_late_ok", int'(issue_ok), 1);

        // 6. Back-to-back issues gated by credit, consumer always ready.
        // A=i,B=1,C=0,D=1 gives (i+1-1)*1 = i.
        issued = 0;
        received = 0;
        res_ready = 1'b1;
        for (int c = 0; c < 60 && received < 10; c++) begin
            if (issued < 10 && issue_ok) begin
                set_ops(issued, 1, 0, 1);
                issue = 1'b1;
                issued++;
            end else begin
                issue = 1'b0;
            end
            if (res_valid) begin
                check("t6_data", int'(res_data), received);
                received++;
            end
            tick();
        end
        issue = 1'b0;
        check("t6_count", received, 10);
        check("t6_err", int'(err_drop), 0);
        check("t6_final_occ", int'(occupancy), 0);
        check("t6_final_ok", int'(issue_ok), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
